// File: rtl/fetch_ctrl_r32i.sv
// rtl/fetch_ctrl_r32i.sv - RV32I instruction-fetch sequencer with one-entry output register
module fetch_ctrl_r32i #(
  parameter int unsigned      dataW     = 32,
  parameter logic [dataW-1:0] ResetAddr = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             BranchTaken,
  input  logic [dataW-1:0] BranchTarget,
  output logic             MemReq,
  output logic [dataW-1:0] MemAddr,
  input  logic             MemGnt,
  input  logic             MemRValid,
  input  logic [31:0]      MemRData,
  output logic             InstrValid,
  output logic [31:0]      Instr,
  output logic [dataW-1:0] InstrAddr,
  input  logic             InstrReady,
  output logic             Fault
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [dataW-1:0] pc_q, pc_d;
  logic [dataW-1:0] addr_q, addr_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic             issue_ok;

  // Issue only into an empty or draining output register, and never in a redirect cycle.
  always_comb begin
    issue_ok = (state_q == ST_REQ) && !reset && !BranchTaken && (!valid_q || InstrReady);
  end

  assign MemReq     = issue_ok;
  assign MemAddr    = pc_q;
  assign InstrValid = valid_q;
  assign Instr      = instr_q;
  assign InstrAddr  = addr_q;
  assign Fault      = fault_q;

  // Next state: normal fetch progress first, then a redirect overrides everything it touches.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    fault_d = fault_q;

    if (valid_q && InstrReady) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_REQ: begin
        if (issue_ok && MemGnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (MemRValid) begin
          valid_d = 1'b1;
          instr_d = MemRData;
          addr_d  = pc_q;
          pc_d    = pc_q + dataW'(4);
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (MemRValid) begin
          state_d = ST_REQ;
        end
      end
      ST_FAULT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    // A redirect flushes the output register and discards any response landing this cycle.
    if (BranchTaken && (state_q != ST_FAULT)) begin
      pc_d    = BranchTarget;
      valid_d = 1'b0;
      instr_d = instr_q;
      addr_d  = addr_q;
      if (BranchTarget[1:0] != 2'b00) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end else if (state_q == ST_REQ) begin
        state_d = ST_REQ;
      end else begin
        state_d = MemRValid ? ST_REQ : ST_DROP;
      end
    end
  end

  // State and output register update with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_REQ;
      pc_q    <= ResetAddr;
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl_r32i.sv
// tb/tb_fetch_ctrl_r32i.sv - directed bench with reference model for fetch_ctrl_r32i
module tb_fetch_ctrl_r32i;

  logic        clk;
  logic        rst, br, gnt, rdy;
  logic [31:0] tgt;
  logic        rv   [2];
  logic [31:0] rd   [2];
  logic        mreq [2];
  logic [31:0] maddr[2];
  logic        ival [2];
  logic [31:0] ins  [2];
  logic [31:0] iad  [2];
  logic        flt  [2];

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  bit chk_en, track8, seen8;

  // memory responder state
  bit          pend [2];
  logic [31:0] paddr[2];
  int          cnt  [2];
  logic [31:0] iss0[$];
  logic [31:0] iss1[$];

  // reference model: fetch pointer, outstanding request (0 none, 1 live, 2 stale), output slot
  logic [31:0] m_pc[2], m_oi[2], m_oa[2];
  int          m_out[2];
  bit          m_ov[2], m_fault[2];
  logic [31:0] x_pc[2], x_oi[2], x_oa[2];
  int          x_out[2];
  bit          x_ov[2], x_fault[2];

  fetch_ctrl_r32i #(.dataW(32), .ResetAddr(32'h0000_0000)) dut0 (
    .clock(clk), .reset(rst), .BranchTaken(br), .BranchTarget(tgt),
    .MemReq(mreq[0]), .MemAddr(maddr[0]), .MemGnt(gnt), .MemRValid(rv[0]), .MemRData(rd[0]),
    .InstrValid(ival[0]), .Instr(ins[0]), .InstrAddr(iad[0]), .InstrReady(rdy), .Fault(flt[0])
  );

  fetch_ctrl_r32i #(.dataW(32), .ResetAddr(32'hFFFF_FFFC)) dut1 (
    .clock(clk), .reset(rst), .BranchTaken(br), .BranchTarget(tgt),
    .MemReq(mreq[1]), .MemAddr(maddr[1]), .MemGnt(gnt), .MemRValid(rv[1]), .MemRData(rd[1]),
    .InstrValid(ival[1]), .Instr(ins[1]), .InstrAddr(iad[1]), .InstrReady(rdy), .Fault(flt[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] img(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ra(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are checked against the model,
  // grants are recorded, then the model advances across the edge.
  task automatic tick();
    bit req_e;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0;
      if (pend[i]) begin
        if (cnt[i] == 0) begin
          rv[i]   = 1'b1;
          rd[i]   = img(paddr[i]);
          pend[i] = 1'b0;
        end else begin
          cnt[i]--;
        end
      end
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      req_e = !rst && !m_fault[i] && (m_out[i] == 0) && !br && (!m_ov[i] || rdy);
      if (chk_en) begin
        if (track8 && (i == 0) && ival[0] && (iad[0] == 32'h8)) seen8 = 1'b1;
        chk($sformatf("u%0d MemReq", i), mreq[i], req_e);
        if (req_e) chk($sformatf("u%0d MemAddr", i), maddr[i], m_pc[i]);
        chk($sformatf("u%0d InstrValid", i), ival[i], m_ov[i]);
        chk($sformatf("u%0d Fault", i), flt[i], m_fault[i]);
        if (m_ov[i]) begin
          chk($sformatf("u%0d Instr", i), ins[i], m_oi[i]);
          chk($sformatf("u%0d InstrAddr", i), iad[i], m_oa[i]);
        end
      end
      if (mreq[i] === 1'b1 && gnt) begin
        pend[i]  = 1'b1;
        paddr[i] = maddr[i];
        cnt[i]   = lat;
        if (i == 0) iss0.push_back(maddr[i]);
        else        iss1.push_back(maddr[i]);
      end
      x_pc[i] = m_pc[i]; x_oi[i] = m_oi[i]; x_oa[i] = m_oa[i];
      x_out[i] = m_out[i]; x_ov[i] = m_ov[i]; x_fault[i] = m_fault[i];
      if (rst) begin
        x_pc[i] = ra(i); x_out[i] = 0; x_ov[i] = 0; x_oi[i] = 0; x_oa[i] = 0; x_fault[i] = 0;
      end else if (!m_fault[i]) begin
        if (br) begin
          x_pc[i] = tgt;
          x_ov[i] = 0;
          if (tgt[1:0] != 2'b00) begin
            x_fault[i] = 1; x_out[i] = 0;
          end else if (m_out[i] != 0 && !rv[i]) begin
            x_out[i] = 2;
          end else begin
            x_out[i] = 0;
          end
        end else begin
          if (m_ov[i] && rdy) x_ov[i] = 0;
          if (rv[i]) begin
            if (m_out[i] == 1) begin
              x_ov[i] = 1; x_oi[i] = rd[i]; x_oa[i] = m_pc[i]; x_pc[i] = m_pc[i] + 32'd4;
            end
            x_out[i] = 0;
          end
          if (req_e && gnt) x_out[i] = 1;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = x_pc[i]; m_oi[i] = x_oi[i]; m_oa[i] = x_oa[i];
      m_out[i] = x_out[i]; m_ov[i] = x_ov[i]; m_fault[i] = x_fault[i];
      if (rst) pend[i] = 1'b0;
    end
  endtask

  initial begin
    int sz;
    logic [31:0] e0 [4];
    logic [31:0] e1 [4];
    rst = 1; br = 0; tgt = 0; rdy = 1; gnt = 1; lat = 0;
    chk_en = 0; track8 = 0; seen8 = 0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; rd[i] = 0; pend[i] = 0; paddr[i] = 0; cnt[i] = 0;
      m_pc[i] = 0; m_oi[i] = 0; m_oa[i] = 0; m_out[i] = 0; m_ov[i] = 0; m_fault[i] = 0;
    end

    // reset state
    tick();
    chk_en = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst InstrValid", ival[i], 0);
      chk("rst Instr", ins[i], 0);
      chk("rst InstrAddr", iad[i], 0);
      chk("rst Fault", flt[i], 0);
    end
    rst = 0;

    // streaming fetch with immediate grant and one-cycle response
    repeat (8) tick();
    e0 = '{32'h0, 32'h4, 32'h8, 32'hC};
    e1 = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    chk("iss0 count", iss0.size(), 4);
    chk("iss1 count", iss1.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < iss0.size()) chk("seq u0", iss0[k], e0[k]);
      if (k < iss1.size()) chk("seq u1 wrap", iss1[k], e1[k]);
    end
    chk("last instr u0", iad[0], 32'hC);
    chk("last word u0", ins[0], img(32'hC));

    // back-pressure holds the output register and blocks requests
    rdy = 0;
    repeat (5) begin
      tick();
      chk("bp InstrAddr", iad[0], 32'hC);
      chk("bp Instr", ins[0], img(32'hC));
      chk("bp MemReq", mreq[0], 0);
    end
    rdy = 1;
    #1;
    chk("bp release MemReq", mreq[0], 1);
    chk("bp release MemAddr", maddr[0], 32'h10);
    tick(); tick(); tick();

    // redirect while the response for 0x8 is pending
    lat = 1; rst = 1; tick(); rst = 0; track8 = 1;
    repeat (7) tick();
    br = 1; tgt = 32'h100; tick(); br = 0; lat = 0;
    tick(); tick();
    chk("redir target u0", iss0[iss0.size()-1], 32'h100);
    chk("redir target u1", iss1[iss1.size()-1], 32'h100);
    tick(); tick();
    track8 = 0;
    chk("stale 0x8 never shown", seen8, 0);

    // redirect coinciding with a response in WAIT
    br = 1; tgt = 32'h200; tick(); br = 0;
    chk("rv+br discarded", ival[0], 0);
    tick();
    chk("after rv+br target", iss0[iss0.size()-1], 32'h200);
    tick();
    chk("0x200 loaded", iad[0], 32'h200);

    // redirect while the output register is stalled
    rdy = 0; tick();
    chk("stalled valid", ival[0], 1);
    br = 1; tgt = 32'h300; tick(); br = 0;
    chk("stalled flush", ival[0], 0);
    rdy = 1; tick();
    chk("flush target", iss0[iss0.size()-1], 32'h300);
    tick();
    chk("0x300 loaded", iad[0], 32'h300);

    // misaligned target faults until reset; later redirects are ignored
    sz = iss0.size();
    br = 1; tgt = 32'h102; tick(); br = 0;
    chk("fault set u0", flt[0], 1);
    chk("fault set u1", flt[1], 1);
    chk("fault valid", ival[0], 0);
    repeat (3) tick();
    br = 1; tgt = 32'h40; tick(); br = 0;
    repeat (2) tick();
    chk("fault sticky", flt[0], 1);
    chk("fault no req", mreq[0], 0);
    chk("fault no issue", iss0.size(), sz);
    rst = 1; tick(); rst = 0;
    chk("fault cleared", flt[0], 0);
    tick();
    chk("restart u0", iss0[iss0.size()-1], 32'h0);
    chk("restart u1", iss1[iss1.size()-1], 32'hFFFF_FFFC);
    tick();

    // reset asserted while waiting for a response
    lat = 2; tick();
    rst = 1; tick(); rst = 0;
    #1;
    chk("rst-in-wait req", mreq[0], 1);
    chk("rst-in-wait addr u0", maddr[0], 32'h0);
    chk("rst-in-wait addr u1", maddr[1], 32'hFFFF_FFFC);
    tick(); tick(); tick(); tick();
    chk("rst-in-wait fetch u0", iad[0], 32'h0);
    chk("rst-in-wait fetch u1", iad[1], 32'hFFFF_FFFC);
    chk("rst-in-wait valid", ival[0], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
